// File: rtl/iir_cap_pkg.sv
// Shared types, defaults and helpers for the filter response capture block.
package iir_cap_pkg;

    // Defaults shared with the stimulus side (50 MHz clock, 1 MHz sample rate).
    localparam int unsigned CapT    = 50;
    localparam int unsigned CapN    = 113;
    localparam int unsigned CapDw   = 32;
    localparam int unsigned AbsMaxW = 64;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2
    } cap_state_e;

    // Absolute value of a w-bit signed number (sign-extended into x), with the
    // most negative code saturating to the most positive one.
    function automatic logic [AbsMaxW-1:0] abs_sat(input logic signed [AbsMaxW-1:0] x,
                                                   input int unsigned w);
        logic [AbsMaxW-1:0]        max_v;
        logic signed [AbsMaxW-1:0] min_v;
        max_v = (AbsMaxW'(1) << (w - 1)) - AbsMaxW'(1);
        min_v = $signed(~max_v);
        if (x == min_v) begin
            abs_sat = max_v;
        end else if (x < 0) begin
            abs_sat = $unsigned(-x);
        end else begin
            abs_sat = $unsigned(x);
        end
    endfunction

endpackage

// File: rtl/iir_cap_ram.sv
// Simple dual-port capture buffer: synchronous write, registered read, array not reset.
module iir_cap_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned N  = 113,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] rdata_d, rdata_q;

    // Array write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read lookup; a same-cycle write is not forwarded, so old data is returned.
    always_comb begin
        rdata_d = mem_q[raddr_i];
    end

    // Read data register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Output drive.
    always_comb begin
        rdata_o = rdata_q;
    end

endmodule

// File: rtl/iir_resp_capture.sv
// Captures N filter output samples at one sample per T enabled clocks and
// measures peak magnitude and settling index.
module iir_resp_capture
    import iir_cap_pkg::*;
#(
    parameter int unsigned T          = CapT,
    parameter int unsigned N          = CapN,
    parameter int unsigned DW         = CapDw,
    parameter int unsigned AW         = $clog2(N),
    parameter int unsigned SETTLE_TH  = 4,
    parameter int unsigned SETTLE_LEN = 8
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          clk_en,
    input  logic          start,
    input  logic [DW-1:0] o_signal,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          settled,
    output logic [AW-1:0] settle_idx,
    output logic [DW-1:0] peak,
    output logic [AW:0]   sample_cnt
);

    localparam int unsigned PW = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned RW = $clog2(SETTLE_LEN + 1);
    localparam logic [PW-1:0] PerLast = PW'(T - 1);
    localparam logic [AW:0]   CntLast = (AW + 1)'(N - 1);
    localparam logic [RW-1:0] RunFull = RW'(SETTLE_LEN);

    cap_state_e state_q, state_d;
    logic          start_q, start_d;
    logic [PW-1:0] per_q, per_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] peak_q, peak_d;
    logic [RW-1:0] run_q, run_d;
    logic          settled_q, settled_d;
    logic [AW-1:0] sidx_q, sidx_d;

    logic                      start_edge;
    logic                      strobe;
    logic signed [AbsMaxW-1:0] samp_ext;
    logic [AbsMaxW-1:0]        abs_full;
    logic [DW-1:0]             abs_v;
    logic                      unused_abs;

    // Start edge detect, sample strobe and sample magnitude.
    always_comb begin
        start_d    = start;
        start_edge = start & ~start_q;
        strobe     = (state_q == StCapture) && clk_en && (per_q == PerLast);
        samp_ext   = AbsMaxW'($signed(o_signal));
        abs_full   = abs_sat(samp_ext, DW);
        abs_v      = abs_full[DW-1:0];
        // Upper bits are always zero for DW below AbsMaxW.
        unused_abs = ^abs_full;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; start edges are ignored while capturing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (start_edge) state_d = StCapture;
            StCapture:      if (strobe && (cnt_q == CntLast)) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == StCapture);
        done = (state_q == StDone);
    end

    // Datapath next state: period counter, sample count, peak and settling tracker.
    always_comb begin
        per_d     = per_q;
        cnt_d     = cnt_q;
        peak_d    = peak_q;
        run_d     = run_q;
        settled_d = settled_q;
        sidx_d    = sidx_q;
        if (start_edge && (state_q != StCapture)) begin
            per_d     = '0;
            cnt_d     = '0;
            peak_d    = '0;
            run_d     = '0;
            settled_d = 1'b0;
            sidx_d    = '0;
        end else if (strobe) begin
            per_d = '0;
            cnt_d = cnt_q + 1'b1;
            if (abs_v > peak_q) begin
                peak_d = abs_v;
            end
            if (abs_v <= DW'(SETTLE_TH)) begin
                run_d = (run_q == RunFull) ? run_q : run_q + 1'b1;
            end else begin
                run_d = '0;
            end
            // Current index is cnt_q; the qualifying run began SETTLE_LEN-1 samples earlier.
            if (!settled_q && (run_d == RunFull)) begin
                settled_d = 1'b1;
                sidx_d    = cnt_q[AW-1:0] - AW'(SETTLE_LEN - 1);
            end
        end else if ((state_q == StCapture) && clk_en) begin
            per_d = per_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            start_q   <= 1'b0;
            per_q     <= '0;
            cnt_q     <= '0;
            peak_q    <= '0;
            run_q     <= '0;
            settled_q <= 1'b0;
            sidx_q    <= '0;
        end else begin
            start_q   <= start_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            peak_q    <= peak_d;
            run_q     <= run_d;
            settled_q <= settled_d;
            sidx_q    <= sidx_d;
        end
    end

    // Result outputs.
    always_comb begin
        sample_cnt = cnt_q;
        peak       = peak_q;
        settled    = settled_q;
        settle_idx = sidx_q;
    end

    iir_cap_ram #(
        .DW(DW),
        .N (N),
        .AW(AW)
    ) u_ram (
        .clk_i  (clk),
        .rst_ni (reset_l),
        .we_i   (strobe),
        .waddr_i(cnt_q[AW-1:0]),
        .wdata_i(o_signal),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

endmodule

// File: tb/tb_iir_resp_capture.sv
// Self-checking bench for iir_resp_capture: a sample-list reference model is
// compared against the DUT on every negedge, plus literal end-of-run checks.
module tb_iir_resp_capture;

    localparam int T   = 50;
    localparam int N   = 113;
    localparam int TH  = 4;
    localparam int LEN = 8;

    logic        clk, reset_l, clk_en, start;
    logic [31:0] o_signal;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data, peak;
    logic        busy, done, settled;
    logic [6:0]  settle_idx;
    logic [7:0]  sample_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: the list of samples captured in the current run.
    bit          m_busy, m_done, m_prev_start, m_rd_known;
    int          m_en_cnt;
    logic [31:0] m_cap[$];
    logic [31:0] m_mem[N];
    bit          m_written[N];
    logic [31:0] m_rd;

    iir_resp_capture dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .clk_en    (clk_en),
        .start     (start),
        .o_signal  (o_signal),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .settled   (settled),
        .settle_idx(settle_idx),
        .peak      (peak),
        .sample_cnt(sample_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned mabs(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        if (s < 0) s = -s;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        return longint'(unsigned'(s));
    endfunction

    function automatic longint unsigned model_peak();
        longint unsigned p;
        p = 0;
        foreach (m_cap[i]) if (mabs(m_cap[i]) > p) p = mabs(m_cap[i]);
        return p;
    endfunction

    function automatic void model_settle(output bit found, output int idx);
        int run;
        found = 0;
        idx   = 0;
        run   = 0;
        foreach (m_cap[i]) begin
            if (mabs(m_cap[i]) <= TH) run++;
            else run = 0;
            if (!found && run == LEN) begin
                found = 1;
                idx   = i - (LEN - 1);
            end
        end
    endfunction

    function automatic logic [31:0] decay_val(input int i);
        case (i)
            0:       return 32'h8000_0000;
            1:       return 32'd100;
            2:       return 32'hFFFF_FFCE;
            3:       return 32'd25;
            4:       return 32'hFFFF_FFF4;
            5:       return 32'd6;
            6:       return 32'd3;
            7:       return 32'hFFFF_FFFE;
            8:       return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: advances on every clock edge or reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge reset_l);
            if (!reset_l) begin
                m_busy = 0; m_done = 0; m_prev_start = 0; m_en_cnt = 0;
                m_cap.delete();
                m_rd = '0; m_rd_known = 1;
            end else begin
                bit edge_seen;
                if (int'(rd_addr) < N) begin
                    m_rd       = m_mem[rd_addr];
                    m_rd_known = m_written[rd_addr];
                end else begin
                    m_rd_known = 0;
                end
                edge_seen    = start && !m_prev_start;
                m_prev_start = start;
                if (m_busy) begin
                    if (clk_en) begin
                        m_en_cnt++;
                        if (m_en_cnt == T) begin
                            m_en_cnt = 0;
                            m_mem[m_cap.size()]     = o_signal;
                            m_written[m_cap.size()] = 1;
                            m_cap.push_back(o_signal);
                            if (m_cap.size() == N) begin
                                m_busy = 0;
                                m_done = 1;
                            end
                        end
                    end
                end else if (edge_seen) begin
                    m_cap.delete();
                    m_en_cnt = 0;
                    m_busy   = 1;
                    m_done   = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            bit found;
            int idx;
            @(negedge clk);
            model_settle(found, idx);
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("sample_cnt", 64'(sample_cnt), 64'(m_cap.size()));
            check("peak", 64'(peak), model_peak());
            check("settled", 64'(settled), 64'(found));
            check("settle_idx", 64'(settle_idx), 64'(idx));
            if (m_rd_known) check("rd_data", 64'(rd_data), 64'(m_rd));
        end
    end

    // mode: 0 impulse, 1 decay, 2 alternating +-5, 3 random. en_mode: 0 on, 1 toggle, 2 random.
    task automatic drive(input int mode, input int en_mode);
        int r;
        case (en_mode)
            0:       clk_en = 1'b1;
            1:       clk_en = ~clk_en;
            default: clk_en = ($urandom_range(0, 3) != 0);
        endcase
        case (mode)
            0: o_signal = (m_cap.size() == 0) ? 32'd1000 : 32'd0;
            1: o_signal = decay_val(m_cap.size());
            2: o_signal = (m_cap.size() % 2 == 0) ? 32'd5 : 32'hFFFF_FFFB;
            default: begin
                r = int'($urandom_range(0, 15));
                if (r == 0) o_signal = $urandom;
                else if (r == 1) o_signal = 32'h8000_0000;
                else o_signal = 32'($urandom_range(0, 12)) - 32'd6;
            end
        endcase
        rd_addr = 7'($urandom_range(0, 127));
    endtask

    // Starts a run at the current negedge and drives it until done, or aborts
    // with a reset once abort_at samples are captured. dur = busy-to-done cycles.
    task automatic run_capture(input int mode, input int en_mode, input int abort_at,
                               input bit mid_start, output int dur);
        int guard, t_busy, mark;
        bit did_mid, finished;
        guard = 0; t_busy = -1; mark = 0; did_mid = 0; finished = 0; dur = -1;
        start = 1'b1;
        drive(mode, en_mode);
        while (!finished && guard < 40000) begin
            @(negedge clk);
            guard++;
            if (t_busy < 0 && busy) t_busy = guard;
            if (done) begin
                finished = 1;
                dur = guard - t_busy;
            end else begin
                if (guard == 3) start = 1'b0;
                if (mid_start && !did_mid && m_cap.size() == 20) begin
                    start = 1'b1; did_mid = 1; mark = guard;
                end
                if (did_mid && guard == mark + 2) start = 1'b0;
                if (abort_at > 0 && m_cap.size() == abort_at) begin
                    @(posedge clk);
                    #2 reset_l = 1'b0;
                    #1;
                    check("abort_busy", 64'(busy), 64'd0);
                    check("abort_cnt", 64'(sample_cnt), 64'd0);
                    check("abort_done", 64'(done), 64'd0);
                    @(negedge clk);
                    @(negedge clk);
                    reset_l = 1'b1;
                    start   = 1'b0;
                    return;
                end
                drive(mode, en_mode);
            end
        end
        start = 1'b0;
        if (!finished) check("run_timeout_done", 64'(done), 64'd1);
    endtask

    initial begin
        int dur;
        reset_l = 1'b0; start = 1'b0; clk_en = 1'b0; o_signal = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        reset_l = 1'b1;

        // Idle: no start edge for 500 clocks.
        repeat (500) begin
            @(negedge clk);
            clk_en   = $urandom_range(0, 1) == 1;
            o_signal = $urandom;
            rd_addr  = 7'($urandom_range(0, 127));
        end
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_peak", 64'(peak), 64'd0);
        check("idle_cnt", 64'(sample_cnt), 64'd0);

        // Impulse with clk_en always high.
        run_capture(0, 0, 0, 0, dur);
        check("imp_dur", 64'(dur), 64'(N * T));
        check("imp_cnt", 64'(sample_cnt), 64'(N));
        check("imp_done", 64'(done), 64'd1);
        check("imp_peak", 64'(peak), 64'd1000);
        check("imp_settled", 64'(settled), 64'd1);
        check("imp_settle_idx", 64'(settle_idx), 64'd1);
        for (int a = 0; a < N; a++) begin
            rd_addr = 7'(a);
            @(negedge clk);
            check("imp_readback", 64'(rd_data), (a == 0) ? 64'd1000 : 64'd0);
        end

        // clk_en at 50% duty: strobes spaced 2T clocks.
        run_capture(0, 1, 0, 0, dur);
        check("gated_dur_in_range",
              64'((dur >= 2 * N * T - 2) && (dur <= 2 * N * T + 2)), 64'd1);
        check("gated_peak", 64'(peak), 64'd1000);

        // Negative full scale followed by a decaying stream.
        run_capture(1, 0, 0, 0, dur);
        check("neg_peak", 64'(peak), 64'h7FFF_FFFF);
        check("decay_settled", 64'(settled), 64'd1);
        check("decay_settle_idx", 64'(settle_idx), 64'd6);

        // Alternating +-5 never settles.
        run_capture(2, 0, 0, 0, dur);
        check("alt_settled", 64'(settled), 64'd0);
        check("alt_peak", 64'(peak), 64'd5);

        // Reset at sample 40 (with an ignored mid-run start), then a full random run.
        run_capture(3, 0, 40, 1, dur);
        @(negedge clk);
        run_capture(3, 2, 0, 1, dur);
        check("restart_cnt", 64'(sample_cnt), 64'(N));
        check("restart_done", 64'(done), 64'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
